// File: rtl/ecc16_check_correct.sv
// ecc16_check_correct: SEC check/correct of a 16-bit word against 8 parity bits, 2-stage valid/ready pipeline
module ecc16_check_correct #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic [7:0]       in_check,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [1:0]       out_status,
   output logic [7:0]       out_syndrome,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt
);
   logic        en;
   logic        hs;
   logic        s1_valid;
   logic [15:0] s1_data;
   logic [7:0]  s1_syn;
   logic [7:0]  syn;
   logic        single;
   logic        corr;
   logic [3:0]  idx;
   logic [1:0]  status;
   logic [15:0] fixed;

   // regenerated check bits: odd/even halves, bit-pair groups, upper/lower byte
   assign syn = in_check ^ {^(in_data & 16'hAAAA), ^(in_data & 16'h5555),
                            ^(in_data & 16'hC0C0), ^(in_data & 16'h3030),
                            ^(in_data & 16'h0C0C), ^(in_data & 16'h0303),
                            ^in_data[15:8], ^in_data[7:0]};
   assign en       = !out_valid | out_ready;
   assign in_ready = en;
   assign hs       = out_valid & out_ready;

   // a correctable syndrome has one bit in each of the byte, pair-group and parity fields
   always_comb begin
      single = $countones(s1_syn) == 1;
      corr   = $onehot(s1_syn[1:0]) & $onehot(s1_syn[5:2]) & $onehot(s1_syn[7:6]);
      idx    = {s1_syn[1], s1_syn[5] | s1_syn[4], s1_syn[5] | s1_syn[3], s1_syn[7]};
      status = s1_syn == 8'd0 ? 2'b00 : single ? 2'b10 : corr ? 2'b01 : 2'b11;
      fixed  = corr ? s1_data ^ (16'd1 << idx) : s1_data;
   end

   // both stages advance together whenever the output slot is free or being drained
   always_ff @(posedge clk)
      if (rst) begin
         s1_valid     <= 1'b0;
         s1_data      <= '0;
         s1_syn       <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_status   <= 2'b00;
         out_syndrome <= '0;
      end else if (en) begin
         s1_valid     <= in_valid;
         s1_data      <= in_data;
         s1_syn       <= syn;
         out_valid    <= s1_valid;
         out_data     <= fixed;
         out_status   <= status;
         out_syndrome <= s1_syn;
      end

   // saturating event counters bumped on delivered results; clear beats a same-cycle bump
   always_ff @(posedge clk)
      if (rst | cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (hs) begin
         if (out_status == 2'b01 && !(&corr_cnt)) corr_cnt <= corr_cnt + 1'b1;
         if (out_status == 2'b11 && !(&uncorr_cnt)) uncorr_cnt <= uncorr_cnt + 1'b1;
      end
endmodule

// File: tb/tb_ecc16_check_correct.sv
// tb_ecc16_check_correct: directed and random checks of ecc16_check_correct against a syndrome-pattern model
module tb_ecc16_check_correct;
   localparam int CNT_W = 2;
   localparam int CMAX = (1 << CNT_W) - 1;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  st;
      logic [7:0]  syn;
   } exp_t;

   logic             clk = 0;
   logic             rst = 1;
   logic             in_valid = 0;
   logic             in_ready;
   logic [15:0]      in_data = 0;
   logic [7:0]       in_check = 0;
   logic             out_valid;
   logic             out_ready = 1;
   logic [15:0]      out_data;
   logic [1:0]       out_status;
   logic [7:0]       out_syndrome;
   logic             cnt_clr = 0;
   logic [CNT_W-1:0] corr_cnt;
   logic [CNT_W-1:0] uncorr_cnt;

   int   checks = 0;
   int   errors = 0;
   int   delivered = 0;
   int   m_corr = 0;
   int   m_uncorr = 0;
   bit   mon_on = 0;
   bit   rnd = 0;
   bit   hold = 0;
   logic [15:0] h_data;
   logic [1:0]  h_st;
   logic [7:0]  h_syn;
   logic [15:0] last_data;
   logic [1:0]  last_st;
   logic [7:0]  last_syn;
   exp_t q[$];

   ecc16_check_correct #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_check(in_check), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_status(out_status),
      .out_syndrome(out_syndrome), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
      .uncorr_cnt(uncorr_cnt)
   );

   always #5 clk = ~clk;

   // syndrome bits a single error in data bit i lights: byte, pair group, parity
   function automatic logic [7:0] pat(input int i);
      logic [7:0] p;
      p = 8'd0;
      p[i / 8] = 1'b1;
      p[2 + (i / 2) % 4] = 1'b1;
      p[6 + i % 2] = 1'b1;
      return p;
   endfunction

   function automatic exp_t model(input logic [15:0] d, input logic [7:0] c);
      exp_t e;
      logic [7:0] s;
      s = c;
      for (int i = 0; i < 16; i++) if (d[i]) s ^= pat(i);
      e.syn = s;
      e.d = d;
      e.st = 2'b11;
      if (s == 8'd0) e.st = 2'b00;
      else if ($countones(s) == 1) e.st = 2'b10;
      else for (int i = 0; i < 16; i++) if (s == pat(i)) begin
         e.st = 2'b01;
         e.d = d ^ (16'd1 << i);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0h want %0h", tag, got, want);
      end
   endtask

   // scoreboard: delivered results, counters and stall stability, sampled mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (mon_on) begin
         chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
         chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
         if (hold) begin
            chk("stall_data", 32'(out_data), 32'(h_data));
            chk("stall_status", 32'(out_status), 32'(h_st));
            chk("stall_syn", 32'(out_syndrome), 32'(h_syn));
         end
         if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      hold = out_valid && !out_ready && !rst;
      h_data = out_data;
      h_st = out_status;
      h_syn = out_syndrome;
      if (rst) begin
         q.delete();
         m_corr = 0;
         m_uncorr = 0;
      end else begin
         if (mon_on && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
            else begin
               e = q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_status", 32'(out_status), 32'(e.st));
               chk("out_syn", 32'(out_syndrome), 32'(e.syn));
               last_data = out_data;
               last_st = out_status;
               last_syn = out_syndrome;
               delivered++;
               if (!cnt_clr && e.st == 2'b01 && m_corr < CMAX) m_corr++;
               if (!cnt_clr && e.st == 2'b11 && m_uncorr < CMAX) m_uncorr++;
            end
         end
         if (cnt_clr) begin
            m_corr = 0;
            m_uncorr = 0;
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic [7:0] c);
      int n = 0;
      in_valid = 1;
      in_data = d;
      in_check = c;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      chk("send_accept", 32'(in_ready), 32'd1);
      if (in_ready) q.push_back(model(d, c));
      @(posedge clk); #1;
      in_valid = 0;
      if (rnd) out_ready = $urandom_range(0, 2) != 0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic beat(input logic [15:0] d, input logic [7:0] c,
                       input logic [15:0] ed, input logic [1:0] es, input logic [7:0] esyn);
      send(d, c);
      drain();
      chk("dir_data", 32'(last_data), 32'(ed));
      chk("dir_status", 32'(last_st), 32'(es));
      chk("dir_syn", 32'(last_syn), 32'(esyn));
   endtask

   task automatic pulse_clr();
      cnt_clr = 1;
      @(posedge clk); #1;
      cnt_clr = 0;
   endtask

   initial begin
      int n;
      int base;
      logic [15:0] d;
      logic [7:0]  c;
      logic [23:0] w;
      int a, b;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_status", 32'(out_status), 32'd0);
      chk("rst_out_syn", 32'(out_syndrome), 32'd0);
      chk("rst_corr", 32'(corr_cnt), 32'd0);
      chk("rst_uncorr", 32'(uncorr_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      mon_on = 1;
      @(posedge clk); #1;

      send(16'h0000, 8'h00);
      @(negedge clk);
      chk("lat_edge1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_edge2_valid", 32'(out_valid), 32'd1);
      drain();
      chk("clean0_status", 32'(last_st), 32'd0);

      beat(16'h0001, 8'h45, 16'h0001, 2'b00, 8'h00);
      beat(16'h0020, 8'h00, 16'h0000, 2'b01, 8'h91);
      chk("corr_after_0020", 32'(corr_cnt), 32'd1);
      beat(16'h8000, 8'h00, 16'h0000, 2'b01, 8'hA2);
      beat(16'h0000, 8'h08, 16'h0000, 2'b10, 8'h08);
      chk("corr_after_chkerr", 32'(corr_cnt), 32'd2);
      chk("uncorr_after_chkerr", 32'(uncorr_cnt), 32'd0);
      beat(16'h0003, 8'h00, 16'h0003, 2'b11, 8'hC0);
      chk("uncorr_after_dbl", 32'(uncorr_cnt), 32'd1);

      pulse_clr();
      base = delivered;
      out_ready = 1;
      fork
         begin
            send(16'h0020, 8'h00);
            send(16'h0003, 8'h00);
            send(16'h1234, model(16'h1234, 8'h00).syn);
            send(16'h8000, 8'h00);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      drain();
      @(posedge clk); #1;
      chk("bp_delivered", 32'(delivered - base), 32'd4);
      chk("bp_corr", 32'(corr_cnt), 32'd2);
      chk("bp_uncorr", 32'(uncorr_cnt), 32'd1);

      pulse_clr();
      repeat (5) send(16'h0020, 8'h00);
      drain();
      @(posedge clk); #1;
      chk("sat_corr", 32'(corr_cnt), 32'(CMAX));

      out_ready = 0;
      send(16'h0020, 8'h00);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("clr_hs_valid", 32'(out_valid), 32'd1);
      cnt_clr = 1;
      out_ready = 1;
      @(posedge clk); #1;
      cnt_clr = 0;
      @(negedge clk);
      chk("clr_hs_corr", 32'(corr_cnt), 32'd0);
      @(posedge clk); #1;

      rnd = 1;
      for (int k = 0; k < 300; k++) begin
         d = 16'($urandom);
         c = model(d, 8'h00).syn;
         w = {c, d};
         a = $urandom_range(0, 23);
         b = (a + $urandom_range(1, 23)) % 24;
         case ($urandom_range(0, 3))
            1: w[$urandom_range(0, 15)] ^= 1'b1;
            2: w[16 + $urandom_range(0, 7)] ^= 1'b1;
            3: begin w[a] ^= 1'b1; w[b] ^= 1'b1; end
            default: ;
         endcase
         if ($urandom_range(0, 9) == 0) pulse_clr();
         send(w[15:0], w[23:16]);
      end
      rnd = 0;
      drain();
      @(posedge clk); #1;

      out_ready = 1;
      send(16'h0020, 8'h00);
      send(16'h0003, 8'h00);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      repeat (5) begin
         @(negedge clk);
         chk("rst_flight_valid", 32'(out_valid), 32'd0);
      end
      chk("rst_flight_corr", 32'(corr_cnt), 32'd0);
      chk("rst_flight_uncorr", 32'(uncorr_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
